// File: rtl/seizure_detector.sv
// Threshold-and-debounce seizure detector: compares each feature sample against a scaled
// baseline and runs a four-state FSM with onset/offset debounce and one-cycle edge pulses.
module seizure_detector #(
  parameter int input_width = 25,
  parameter int base_width  = 37,
  parameter int K_MULT      = 3,
  parameter int K_SHIFT     = 0,
  parameter int ONSET_CNT   = 250,
  parameter int OFFSET_CNT  = 500
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          en,
  input  logic signed [input_width-1:0] feat_in,
  input  logic                          feat_valid,
  input  logic [base_width-1:0]         baseline_in,
  input  logic                          baseline_valid,
  output logic                          alarm,
  output logic                          onset_pulse,
  output logic                          offset_pulse,
  output logic [1:0]                    state
);

  localparam int TW = base_width + 8;
  localparam int CW = (TW > input_width) ? TW : input_width;
  localparam logic [7:0] K_M     = 8'(K_MULT);
  localparam logic [9:0] ONSET_C = 10'(ONSET_CNT);
  localparam logic [9:0] OFF_C   = 10'(OFFSET_CNT);
  localparam logic [9:0] CNT_MAX = 10'd1023;

  typedef enum logic [1:0] {
    WAIT_BASE = 2'd0,
    IDLE      = 2'd1,
    CANDIDATE = 2'd2,
    ALARM     = 2'd3
  } state_t;

  state_t                state_r, state_s;
  logic [base_width-1:0] base_r, base_s;
  logic [9:0]            run_r, run_s, quiet_r, quiet_s;
  logic                  alarm_r, onset_r, offset_r;
  logic                  onset_s, offset_s;
  logic [TW-1:0]         thr_s;
  logic [CW-1:0]         feat_z_s, thr_z_s;
  logic                  exceed_s;
  logic [9:0]            run_inc_s, quiet_inc_s;

  // Full-width product so the multiplier cannot overflow before the shift.
  assign thr_s    = (TW'(base_r) * TW'(K_M)) >> K_SHIFT;
  assign feat_z_s = CW'($unsigned(feat_in));
  assign thr_z_s  = CW'(thr_s);
  assign exceed_s = ~feat_in[input_width-1] & (feat_z_s > thr_z_s);

  assign run_inc_s   = (run_r == CNT_MAX) ? run_r : run_r + 10'd1;
  assign quiet_inc_s = (quiet_r == CNT_MAX) ? quiet_r : quiet_r + 10'd1;

  // Next-state, baseline capture, debounce counters and pulse generation.
  always_comb begin
    state_s  = state_r;
    run_s    = run_r;
    quiet_s  = quiet_r;
    onset_s  = 1'b0;
    offset_s = 1'b0;
    if (baseline_valid && (state_r != ALARM)) begin
      base_s = baseline_in;
    end else begin
      base_s = base_r;
    end
    case (state_r)
      WAIT_BASE: begin
        if (baseline_valid) begin
          state_s = IDLE;
        end else begin
          state_s = WAIT_BASE;
        end
      end
      IDLE: begin
        if (feat_valid && exceed_s) begin
          if (ONSET_C == 10'd1) begin
            state_s = ALARM;
            onset_s = 1'b1;
            quiet_s = 10'd0;
            run_s   = 10'd0;
          end else begin
            state_s = CANDIDATE;
            run_s   = 10'd1;
          end
        end else begin
          state_s = IDLE;
        end
      end
      CANDIDATE: begin
        if (feat_valid) begin
          if (!exceed_s) begin
            state_s = IDLE;
            run_s   = 10'd0;
          end else if (run_inc_s >= ONSET_C) begin
            state_s = ALARM;
            onset_s = 1'b1;
            run_s   = 10'd0;
            quiet_s = 10'd0;
          end else begin
            run_s = run_inc_s;
          end
        end else begin
          state_s = CANDIDATE;
        end
      end
      ALARM: begin
        if (feat_valid) begin
          if (exceed_s) begin
            quiet_s = 10'd0;
          end else if (quiet_inc_s >= OFF_C) begin
            state_s  = IDLE;
            offset_s = 1'b1;
            quiet_s  = 10'd0;
          end else begin
            quiet_s = quiet_inc_s;
          end
        end else begin
          state_s = ALARM;
        end
      end
      default: begin
        state_s = WAIT_BASE;
      end
    endcase
  end

  // State and output registers; en is active-low, so en=1 freezes everything.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r  <= WAIT_BASE;
      base_r   <= '0;
      run_r    <= 10'd0;
      quiet_r  <= 10'd0;
      alarm_r  <= 1'b0;
      onset_r  <= 1'b0;
      offset_r <= 1'b0;
    end else if (!en) begin
      state_r  <= state_s;
      base_r   <= base_s;
      run_r    <= run_s;
      quiet_r  <= quiet_s;
      alarm_r  <= (state_s == ALARM);
      onset_r  <= onset_s;
      offset_r <= offset_s;
    end else begin
      state_r  <= state_r;
      base_r   <= base_r;
      run_r    <= run_r;
      quiet_r  <= quiet_r;
      alarm_r  <= alarm_r;
      onset_r  <= onset_r;
      offset_r <= offset_r;
    end
  end

  assign state        = state_r;
  assign alarm        = alarm_r;
  assign onset_pulse  = onset_r;
  assign offset_pulse = offset_r;

endmodule

// File: doc/seizure_detector.md
SEIZURE_DETECTOR -- requirements
Module: seizure_detector

Interface
REQ-001 The module SHALL have parameter input_width, default 25: width of the signed per-sample feature.
REQ-002 The module SHALL have parameter base_width, default 37: width of the unsigned baseline from the 240 s baseline stage.
REQ-003 The module SHALL have parameter K_MULT, default 3 (8-bit unsigned): threshold multiplier.
REQ-004 The module SHALL have parameter K_SHIFT, default 0: threshold right-shift.
REQ-005 The module SHALL have parameters ONSET_CNT, default 250, and OFFSET_CNT, default 500, both in range 1..1023: consecutive-sample debounce counts.
REQ-006 The module SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-007 The module SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-008 The module SHALL have port en, input, 1 bit: active-low enable; while en=1 all registers hold.
REQ-009 The module SHALL have port feat_in, input, input_width bits, signed: current feature sample.
REQ-010 The module SHALL have port feat_valid, input, 1 bit: feat_in is a new sample this cycle.
REQ-011 The module SHALL have port baseline_in, input, base_width bits: baseline value.
REQ-012 The module SHALL have port baseline_valid, input, 1 bit: baseline_in is valid (level, may stay high).
REQ-013 The module SHALL have port alarm, output, 1 bit: seizure state active.
REQ-014 The module SHALL have port onset_pulse, output, 1 bit: one-cycle pulse on alarm entry.
REQ-015 The module SHALL have port offset_pulse, output, 1 bit: one-cycle pulse on alarm exit.
REQ-016 The module SHALL have port state, output, 2 bits: FSM state code.

Function
REQ-017 The module SHALL implement the FSM states WAIT_BASE=0, IDLE=1, CANDIDATE=2 and ALARM=3, with state driven directly from the state register.
REQ-018 The module SHALL latch baseline_in into base_reg on every enabled cycle with baseline_valid=1, except while in ALARM, where base_reg is frozen.
REQ-019 The module SHALL compute thr = (base_reg * K_MULT) >> K_SHIFT at width base_width+8 with no truncation before the shift.
REQ-020 The module SHALL compute the combinational flag exceed as 1 only when feat_in >= 0 and zero-extended feat_in > thr; a negative feat_in always gives exceed=0.
REQ-021 The module SHALL evaluate exceed only on enabled cycles with feat_valid=1 and SHALL use the base_reg value from before the current edge; a baseline update in the same cycle takes effect on the next sample.
REQ-022 The module SHALL move from WAIT_BASE to IDLE on the first enabled cycle with baseline_valid=1, and SHALL ignore feat_valid while in WAIT_BASE.
REQ-023 The module SHALL, in IDLE on a sample with exceed=1, go to CANDIDATE with run_cnt=1, or go directly to ALARM when ONSET_CNT=1; on exceed=0 it stays in IDLE.
REQ-024 The module SHALL, in CANDIDATE on a sample with exceed=1, increment run_cnt and enter ALARM when run_cnt reaches ONSET_CNT; on exceed=0 it returns to IDLE with run_cnt=0.
REQ-025 The module SHALL, in ALARM, count consecutive exceed=0 samples in quiet_cnt, reset quiet_cnt to 0 on any exceed=1 sample, and enter IDLE when quiet_cnt reaches OFFSET_CNT.
REQ-026 The module SHALL saturate run_cnt and quiet_cnt (10 bits each) at 1023 and never wrap them.
REQ-027 The module SHALL register alarm so that it rises on the same edge as the ALARM transition.
REQ-028 The module SHALL assert onset_pulse for exactly one cycle on the edge that enters ALARM, and offset_pulse for exactly one cycle on the edge that leaves ALARM.
REQ-029 The module SHALL hold all registers, including the pulse outputs, while en=1; a pulse asserted at the start of a held period therefore persists until the next enabled edge.
REQ-030 The module SHALL have a latency of one edge from a qualifying sample to the resulting state, alarm or pulse change.

Reset
REQ-031 The module SHALL, while rst=0, asynchronously force state=WAIT_BASE, base_reg=0, run_cnt=0, quiet_cnt=0, alarm=0, onset_pulse=0 and offset_pulse=0, independent of clk and en.
REQ-032 The module SHALL, on reset asserted mid-ALARM, deassert alarm immediately without producing an offset_pulse, and on release SHALL require a new baseline before any detection.

Verification (bench parameters: ONSET_CNT=4, OFFSET_CNT=3, K_MULT=3, K_SHIFT=0)
REQ-033 The bench SHALL cover onset: baseline 100 (thr 300), then feat 301 x4 -> state goes 1,2,2,2,3; alarm=1 and onset_pulse=1 for one cycle on the 4th sample edge.
REQ-034 The bench SHALL cover the boundary and broken run: feat 300, then feat 301,301,301,300 -> no alarm; state returns to IDLE on the 300 samples.
REQ-035 The bench SHALL cover offset: in ALARM, feat 0,0,500,0,0,0 -> alarm held through the 5th sample; offset_pulse on the 6th; state=1.
REQ-036 The bench SHALL cover simultaneous update and freeze: baseline_in changes 100->50 in the same cycle as feat 200 -> no exceed on that sample; the next feat 200 exceeds; baseline changes during ALARM leave base_reg unchanged.
REQ-037 The bench SHALL cover enable and sign: en=1 for 10 cycles with feat_valid=1 and feat 1000 -> no state change; feat -5 with baseline 0 -> exceed=0.
REQ-038 The bench SHALL cover reset mid-alarm: drive rst=0 between clk edges -> alarm=0 and state=0 immediately with no offset_pulse; after release, feat 1000 with no baseline_valid -> state remains 0.
